systolic_skew_fifo_bank: RTL and testbench

//  Parametrised bank of NUM_CH lock-step FIFOs feeding one edge (north or west) of the MAC array.

---
 rtl/systolic_skew_fifo_bank_if.sv | 32 +++
 rtl/systolic_skew_fifo_bank.sv | 153 +++++++++++++++
 tb/tb_systolic_skew_fifo_bank.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_skew_fifo_bank_if.sv
// Purpose : bundle of write, burst-control and skewed-output signals for one array-edge FIFO bank.
// Latency : n/a (signal bundle only).
// Backpressure: none; the write side sees full/overflow, and the output side cannot stall.
// Ports   : master = producer/consumer side (drives wr_en, wr_data, start);
//           slave  = FIFO bank (drives full, empty, count, busy, done, out_valid, out_data, overflow).
interface systolic_skew_fifo_bank_if #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic                     wr_en;
    logic [NUM_CH*DATA_W-1:0] wr_data;
    logic                     full;
    logic                     empty;
    logic [ADDR_W:0]          count;
    logic                     start;
    logic                     busy;
    logic                     done;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic                     overflow;

    modport master (
        output wr_en, wr_data, start,
        input  full, empty, count, busy, done, out_valid, out_data, overflow
    );

    modport slave (
        input  wr_en, wr_data, start,
        output full, empty, count, busy, done, out_valid, out_data, overflow
    );
endinterface

// File: rtl/systolic_skew_fifo_bank.sv
// Purpose : NUM_CH lock-step FIFOs for one MAC-array edge; bursts stored vectors out with diagonal skew.
// Latency : vector popped in cycle c appears on channel i in cycle c+1+i; done at start+2+len+NUM_CH-1.
// Backpressure: none on the output; writes while full are dropped and set the sticky overflow flag.
// Ports   : clk, reset (async, active-high), bus (slave modport): wr_en/wr_data push one vector,
//           full/empty/count report occupancy, start/busy/done control a burst, out_valid/out_data
//           carry the skewed stream (data zero when invalid), overflow is sticky.
module systolic_skew_fifo_bank #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input logic                      clk,
    input logic                      reset,
    systolic_skew_fifo_bank_if.slave bus
);
    localparam int DRAIN_W = $clog2(NUM_CH);
    localparam int CNT_W   = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         count_q, count_nxt;
    logic [CNT_W-1:0]         rem_q, rem_nxt;       // pops left in the current burst
    logic [DRAIN_W-1:0]       drain_q, drain_nxt;
    logic                     done_q, done_nxt;
    logic                     full_q, empty_q, overflow_q;
    logic [ADDR_W-1:0]        wr_ptr, rd_ptr;
    logic                     push, pop;
    logic [NUM_CH*DATA_W-1:0] mem [DEPTH];
    logic [NUM_CH-1:0]        out_valid_w;
    logic [NUM_CH*DATA_W-1:0] out_data_w;

    assign push      = bus.wr_en && !full_q;
    assign count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);

    // Burst control: burst length is frozen at start so vectors written mid-burst wait for the next one.
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem_q;
        drain_nxt = drain_q;
        done_nxt  = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (count_q != '0) begin
                        rem_nxt   = count_q;
                        state_nxt = STREAM;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            STREAM: begin
                pop     = 1'b1;
                rem_nxt = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    drain_nxt = '0;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // NUM_CH cycles here lets the last vector reach the final channel before done.
                drain_nxt = drain_q + DRAIN_W'(1);
                if (drain_q == DRAIN_W'(NUM_CH - 1)) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rem_q   <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            rem_q   <= rem_nxt;
            drain_q <= drain_nxt;
            done_q  <= done_nxt;
        end
    end

    // Occupancy and pointers, shared by all channels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            count_q <= count_nxt;
            full_q  <= (count_nxt == CNT_W'(DEPTH));
            empty_q <= (count_nxt == '0);
            if (bus.wr_en && full_q)
                overflow_q <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + ADDR_W'(1);
        end
    end

    // Storage is not reset; only slots covered by count are ever read.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.wr_data;
    end

    // Per-channel skew line: stage 0 is the registered RAM read, channel i adds i further stages.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DATA_W-1:0] dat_q [i+1];
        logic [i:0]        vld_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_q <= '0;
                for (int k = 0; k <= i; k++)
                    dat_q[k] <= '0;
            end else begin
                vld_q[0] <= pop;
                dat_q[0] <= pop ? mem[rd_ptr][i*DATA_W +: DATA_W] : '0;
                for (int k = 1; k <= i; k++) begin
                    vld_q[k] <= vld_q[k-1];
                    dat_q[k] <= dat_q[k-1];
                end
            end
        end

        assign out_valid_w[i]                   = vld_q[i];
        assign out_data_w[i*DATA_W +: DATA_W]   = vld_q[i] ? dat_q[i] : '0;
    end

    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.count     = count_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.overflow  = overflow_q;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = out_data_w;
endmodule

// File: tb/tb_systolic_skew_fifo_bank.sv
module tb_systolic_skew_fifo_bank;
    localparam int NUM_CH = 8;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    typedef struct packed {
        logic [7:0]  d;
        logic [31:0] c;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] cyc;
    int          errors;
    int          checks;
    logic [7:0]  seed;

    exp_t        exp_q [NUM_CH][$];
    logic [31:0] done_q [$];
    logic [63:0] model [$];

    systolic_skew_fifo_bank_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    systolic_skew_fifo_bank #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ch i = base + i
    function automatic logic [63:0] mkvec(input logic [7:0] base);
        logic [63:0] v;
        for (int i = 0; i < NUM_CH; i++)
            v[i*8 +: 8] = base + 8'(i);
        return v;
    endfunction

    task automatic write_vec(input logic [7:0] base);
        bus.wr_en   = 1'b1;
        bus.wr_data = mkvec(base);
        if (model.size() < DEPTH)
            model.push_back(mkvec(base));
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic write_n(input int n);
        for (int k = 0; k < n; k++) begin
            write_vec(seed);
            seed = seed + 8'h09;
        end
    endtask

    // Issues start in the current cycle s; vector k is due on ch i in cycle s+2+k+i.
    task automatic do_start();
        int          len;
        logic [31:0] s;
        logic [63:0] v;
        exp_t        e;
        len = model.size();
        s   = cyc;
        for (int k = 0; k < len; k++) begin
            v = model.pop_front();
            for (int i = 0; i < NUM_CH; i++) begin
                e.d = v[i*8 +: 8];
                e.c = s + 2 + 32'(k) + 32'(i);
                exp_q[i].push_back(e);
            end
        end
        done_q.push_back(len == 0 ? s + 1 : s + 1 + 32'(len) + NUM_CH);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("done_timeout_pending", 32'(done_q.size()), 0);
        done_q.delete();
        tick();
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.out_valid[i]) begin
                    checks++;
                    if (exp_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL ch_unexpected: ch%0d valid with data %0h, required no output (cycle %0d)",
                                 i, bus.out_data[i*8 +: 8], cyc);
                    end else begin
                        e = exp_q[i].pop_front();
                        check($sformatf("ch%0d_data", i), 32'(bus.out_data[i*8 +: 8]), 32'(e.d));
                        check($sformatf("ch%0d_cycle", i), cyc, e.c);
                    end
                end else begin
                    check($sformatf("ch%0d_zero_fill", i), 32'(bus.out_data[i*8 +: 8]), 0);
                end
            end
            if (bus.done) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: done=1 at cycle %0d, required 0", cyc);
                end else begin
                    check("done_cycle", cyc, done_q.pop_front());
                end
            end
        end
    end

    task automatic check_idle_reset_state(input string tag);
        check({tag, "_count"},     32'(bus.count), 0);
        check({tag, "_empty"},     32'(bus.empty), 1);
        check({tag, "_full"},      32'(bus.full), 0);
        check({tag, "_busy"},      32'(bus.busy), 0);
        check({tag, "_done"},      32'(bus.done), 0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_out_data"},  bus.out_data[31:0] | bus.out_data[63:32], 0);
        check({tag, "_overflow"},  32'(bus.overflow), 0);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        seed        = 8'h40;
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        #3;
        check_idle_reset_state("reset");
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Three vectors, ch i = 8'h10*v + i.
        for (int v = 0; v < 3; v++)
            write_vec(8'(8'h10 * v));
        check("t2_count", 32'(bus.count), 3);
        do_start();
        check("t2_busy", 32'(bus.busy), 1);
        wait_done();
        check("t2_count_after", 32'(bus.count), 0);
        check("t2_empty_after", 32'(bus.empty), 1);

        // Start on an empty bank: done next cycle, never busy.
        do_start();
        check("t5_busy0", 32'(bus.busy), 0);
        tick();
        check("t5_busy1", 32'(bus.busy), 0);
        tick();
        check("t5_busy2", 32'(bus.busy), 0);
        wait_done();

        // Fill to DEPTH, then one dropped write.
        for (int v = 0; v < DEPTH; v++)
            write_vec(8'(8'h10 * v));
        check("t3_full", 32'(bus.full), 1);
        check("t3_count16", 32'(bus.count), DEPTH);
        check("t3_overflow_pre", 32'(bus.overflow), 0);
        write_vec(8'hEE);
        check("t3_overflow", 32'(bus.overflow), 1);
        check("t3_count_hold", 32'(bus.count), DEPTH);
        do_start();
        wait_done();
        check("t3_overflow_sticky", 32'(bus.overflow), 1);
        check("t3_empty", 32'(bus.empty), 1);

        // Reset asserted mid-burst.
        write_n(5);
        do_start();
        tick();
        tick();
        tick();
        #1;
        reset = 1'b1;
        for (int i = 0; i < NUM_CH; i++)
            exp_q[i].delete();
        done_q.delete();
        model.delete();
        #1;
        check_idle_reset_state("midreset");
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 20; k++)
            tick();
        check("midreset_no_busy", 32'(bus.busy), 0);

        // Writes during STREAM stay for the next burst; second pass runs across the pointer wrap.
        for (int pass = 0; pass < 2; pass++) begin
            write_n(2);
            do_start();
            write_n(2);
            wait_done();
            check($sformatf("t4_count_at_done_p%0d", pass), 32'(bus.count), 2);
            do_start();
            wait_done();
            if (pass == 0) begin
                write_n(11);
                do_start();
                wait_done();
            end
        end

        // Push+pop every cycle at DEPTH-1 across two bursts.
        write_n(DEPTH - 1);
        check("t6_count15", 32'(bus.count), DEPTH - 1);
        for (int b = 0; b < 2; b++) begin
            do_start();
            for (int k = 0; k < DEPTH - 1; k++) begin
                write_vec(seed);
                seed = seed + 8'h09;
                check("t6_count_stable", 32'(bus.count), DEPTH - 1);
            end
            wait_done();
        end
        check("t6_overflow", 32'(bus.overflow), 0);
        check("t6_count_end", 32'(bus.count), DEPTH - 1);
        do_start();
        wait_done();
        check("final_empty", 32'(bus.empty), 1);

        for (int i = 0; i < NUM_CH; i++)
            check($sformatf("ch%0d_leftover", i), 32'(exp_q[i].size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
